ram_port_arbiter: RTL

Two-requester round-robin controller that shares one Pipelined_RAM instance (single port, 16-bit, 1024-deep, registered dout) between two independent masters. It sequences the RAM command inputs and optionally zero-fills the array after reset. It tracks outstanding reads through the RAM's fixed read latency and routes each returned word and parity bit back to the requester that issued it.

---
 rtl/ram_port_arbiter_pkg.sv | 13 +
 rtl/ram_port_arbiter_rd_tag_pipe.sv | 36 +++
 rtl/ram_port_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the two-requester RAM port arbiter: FSM states and requester id.
package ram_port_arbiter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  localparam int ID_W = 1;
  localparam logic [ID_W-1:0] RQ0 = 1'b0;
  localparam logic [ID_W-1:0] RQ1 = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// Read tag pipeline: carries {valid, requester id} alongside the RAM read latency.
module rd_tag_pipe
  import ram_port_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_vld,
  input  logic [ID_W-1:0] push_id,
  output logic            pop_vld,
  output logic [ID_W-1:0] pop_id
);

  logic [RD_LATENCY-1:0] vld_p;
  logic [ID_W-1:0]       id_p [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= push_vld;
      for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Id only matters while its valid bit is set, so it is left unreset.
  always_ff @(posedge clk) begin
    id_p[0] <= push_id;
    for (int i = 1; i < RD_LATENCY; i++) id_p[i] <= id_p[i-1];
  end

  assign pop_vld = vld_p[RD_LATENCY-1];
  assign pop_id  = id_p[RD_LATENCY-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one pipelined single-port RAM between two requesters,
// with optional zero-fill after reset and read-data routing by issue tag.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int MEM_WIDTH     = 16,
  parameter int MEM_DEPTH     = 1024,
  parameter int ADDR_SIZE     = 10,
  parameter int RD_LATENCY    = 2,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [MEM_WIDTH-1:0] wdata0,
  input  logic [MEM_WIDTH-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [MEM_WIDTH-1:0] rdata,
  output logic                 rparity,
  output logic                 init_done,
  output logic                 ram_blk_select,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic                 ram_addr_en,
  output logic                 ram_dout_en,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0] ram_din,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  input  logic                 ram_parity
);

  state_t                 state;
  logic [ADDR_SIZE-1:0]   init_cnt;
  logic [ID_W-1:0]        pref_q;
  logic                   en_q;
  logic [MEM_WIDTH-1:0]   rdata_q;
  logic                   rparity_q;

  logic                   win_vld;
  logic [ID_W-1:0]        win_id;
  logic                   win_we;
  logic [ADDR_SIZE-1:0]   win_addr;
  logic [MEM_WIDTH-1:0]   win_wdata;
  logic                   init_wr;
  logic                   rd_push;
  logic                   pop_vld;
  logic [ID_W-1:0]        pop_id;

  // en_q keeps every command quiet until the first edge with reset released.
  always_comb begin
    win_vld = 1'b0;
    win_id  = RQ0;
    if (en_q && state == ST_ARB) begin
      if (req0 && req1) begin
        win_vld = 1'b1;
        win_id  = pref_q;
      end else if (req0) begin
        win_vld = 1'b1;
        win_id  = RQ0;
      end else if (req1) begin
        win_vld = 1'b1;
        win_id  = RQ1;
      end
    end
  end

  assign win_we    = (win_id == RQ1) ? we1    : we0;
  assign win_addr  = (win_id == RQ1) ? addr1  : addr0;
  assign win_wdata = (win_id == RQ1) ? wdata1 : wdata0;
  assign init_wr   = en_q && (state == ST_INIT);
  assign rd_push   = win_vld && !win_we;

  always_comb begin
    ram_blk_select = 1'b0;
    ram_wr_en      = 1'b0;
    ram_rd_en      = 1'b0;
    ram_addr       = '0;
    ram_din        = '0;
    if (init_wr) begin
      ram_blk_select = 1'b1;
      ram_wr_en      = 1'b1;
      ram_addr       = init_cnt;
    end else if (win_vld) begin
      ram_blk_select = 1'b1;
      ram_wr_en      = win_we;
      ram_rd_en      = !win_we;
      ram_addr       = win_addr;
      ram_din        = win_we ? win_wdata : '0;
    end
  end

  assign gnt0        = win_vld && (win_id == RQ0);
  assign gnt1        = win_vld && (win_id == RQ1);
  assign ram_addr_en = en_q;
  assign ram_dout_en = en_q;
  assign init_done   = en_q && (state == ST_ARB);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= (INIT_ON_RESET != 0) ? ST_INIT : ST_ARB;
      init_cnt <= '0;
      pref_q   <= RQ0;
      en_q     <= 1'b0;
    end else begin
      en_q <= 1'b1;
      case (state)
        ST_INIT: begin
          if (init_wr) begin
            if (init_cnt == ADDR_SIZE'(MEM_DEPTH - 1)) state <= ST_ARB;
            else init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_ARB: begin
          if (win_vld) pref_q <= ~win_id;
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  rd_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .push_vld(rd_push),
    .push_id (win_id),
    .pop_vld (pop_vld),
    .pop_id  (pop_id)
  );

  // Returned word is forwarded in the exit cycle, then held until the next one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q   <= '0;
      rparity_q <= 1'b0;
    end else if (pop_vld) begin
      rdata_q   <= ram_dout;
      rparity_q <= ram_parity;
    end
  end

  assign rvalid0 = pop_vld && (pop_id == RQ0);
  assign rvalid1 = pop_vld && (pop_id == RQ1);
  assign rdata   = pop_vld ? ram_dout   : rdata_q;
  assign rparity = pop_vld ? ram_parity : rparity_q;

endmodule
